// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one sequential shift-add multiplier among
// NUM_REQ requesters, routing each product (or a watchdog error) back to its issuer.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [2*DATA_W-1:0]       resp_y,
  output logic                      resp_err,
  output logic                      mul_ena,
  output logic [2*DATA_W-1:0]       mul_a,
  output logic [2*DATA_W-1:0]       mul_b,
  input  logic [2*DATA_W-1:0]       mul_y,
  input  logic                      mul_done,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id
);

  localparam int PW = 2 * DATA_W;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [IDW-1:0]    last_grant;
  logic [TW-1:0]     timer;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    cand;
  logic              found;
  int unsigned       idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*DATA_W +: DATA_W];
      b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end
  end

  // Scan starts one past the last grant so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(last_grant) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      timer      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      mul_ena    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      grant_id   <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            mul_a     <= PW'(a_arr[winner]);
            mul_b     <= PW'(b_arr[winner]);
            grant_id  <= winner;
            req_ready <= NUM_REQ'(1) << winner;
            mul_ena   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // done takes priority over a coincident timeout
          if (mul_done) begin
            resp_y     <= mul_y;
            resp_err   <= 1'b0;
            resp_valid <= NUM_REQ'(1) << grant_id;
            mul_ena    <= 1'b0;
            last_grant <= grant_id;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_y     <= '0;
            resp_err   <= 1'b1;
            resp_valid <= NUM_REQ'(1) << grant_id;
            mul_ena    <= 1'b0;
            last_grant <= grant_id;
            state      <= RESP;
          end
        end
        RESP: begin
          // wait for the multiplier to see start low before allowing a new grant
          if (!mul_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier model
// and a response scoreboard.
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_y;
  logic        resp_err;
  logic        mul_ena;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [7:0]  mul_y;
  logic        mul_done;
  logic        busy;
  logic [1:0]  grant_id;

  mult_share_arbiter #(.NUM_REQ(4), .DATA_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_y(resp_y),
    .resp_err(resp_err), .mul_ena(mul_ena), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .mul_done(mul_done), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] y;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Multiplier model: done in the lat-th WAIT cycle, optionally held after start drops.
  int unsigned lat = 6;
  bit          never = 1'b0;
  int unsigned hold_extra = 0;
  int unsigned mcnt;
  int unsigned hold_left;

  always @(posedge clk) begin
    if (!rst) begin
      mcnt      <= 0;
      hold_left <= 0;
      mul_done  <= 1'b0;
      mul_y     <= '0;
    end else if (mul_ena) begin
      mcnt      <= mcnt + 1;
      hold_left <= hold_extra;
      mul_y     <= mul_a * mul_b;
      mul_done  <= !never && (mcnt + 1 >= lat);
    end else begin
      mcnt <= 0;
      if (hold_left > 1) hold_left <= hold_left - 1;
      else mul_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && |resp_valid) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_resp: observed resp_valid %b expected none", resp_valid);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_valid", resp_valid, 4'b0001 << e.id);
        chk("resp_y", resp_y, e.y);
        chk("resp_err", resp_err, e.err);
        chk("resp_grant_id", grant_id, e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
  endtask

  task automatic push(input int id, input logic [7:0] y, input logic err);
    exp_t e;
    e.id = id; e.y = y; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string tag, input logic [3:0] exp);
    int n;
    n = 0;
    tick();
    while (!(|req_ready) && n < 100) begin
      tick();
      n++;
    end
    chk(tag, req_ready, exp);
  endtask

  task automatic wait_resp(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!(|resp_valid) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_y"}, resp_y, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_mul_ena"}, mul_ena, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int held;
    int n;
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // single request from requester 2
    set_req(2, 4'd7, 4'd9); push(2, 8'd63, 1'b0);
    tick();
    chk("t1_req_ready", req_ready, 4'b0100);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_mul_a", mul_a, 7);
    chk("t1_mul_b", mul_b, 9);
    chk("t1_mul_ena", mul_ena, 1);
    req_valid[2] = 1'b0;
    wait_resp("t1_latency", 7);
    wait_idle("t1_idle");
    chk("t1_done_low_at_idle", mul_done, 0);
    chk("t1_resp_y_held", resp_y, 63);

    // all four requesting, fresh priority
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    set_req(0, 4'd15, 4'd15); push(0, 8'd225, 1'b0);
    set_req(1, 4'd0, 4'd11);  push(1, 8'd0, 1'b0);
    set_req(2, 4'd3, 4'd5);   push(2, 8'd15, 1'b0);
    set_req(3, 4'd12, 4'd10); push(3, 8'd120, 1'b0);
    wait_ready("t2_grant0", 4'b0001);
    set_req(0, 4'd9, 4'd9); push(0, 8'd81, 1'b0);
    wait_ready("t2_grant1", 4'b0010); req_valid[1] = 1'b0;
    wait_ready("t2_grant2", 4'b0100); req_valid[2] = 1'b0;
    wait_ready("t2_grant3", 4'b1000); req_valid[3] = 1'b0;
    wait_ready("t2_grant4", 4'b0001); req_valid[0] = 1'b0;
    wait_drain("t2_drain");
    wait_idle("t2_idle");

    // multiplier never finishes
    never = 1'b1;
    set_req(3, 4'd5, 4'd5); push(3, 8'd0, 1'b1);
    tick();
    chk("t3_req_ready", req_ready, 4'b1000);
    req_valid[3] = 1'b0;
    wait_resp("t3_timeout_latency", 17);
    wait_idle("t3_idle");
    never = 1'b0;

    // done coincides with the last timer value
    lat = 16;
    set_req(1, 4'd13, 4'd11); push(1, 8'd143, 1'b0);
    tick();
    chk("t4_req_ready", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    wait_resp("t4_latency", 17);
    wait_idle("t4_idle");

    // done held after start drops while requester 1 waits
    lat = 2; hold_extra = 3;
    set_req(0, 4'd6, 4'd7); push(0, 8'd42, 1'b0);
    tick();
    chk("t5_req_ready0", req_ready, 4'b0001);
    req_valid[0] = 1'b0;
    set_req(1, 4'd4, 4'd4); push(1, 8'd16, 1'b0);
    wait_resp("t5_latency0", 3);
    held = 0; n = 0;
    while (!(|req_ready) && n < 30) begin
      if (mul_done) held++;
      tick();
      n++;
    end
    chk("t5_resp_hold_cycles", held, 3);
    chk("t5_regrant_delay", n, 5);
    chk("t5_req_ready1", req_ready, 4'b0010);
    hold_extra = 0;
    req_valid[1] = 1'b0;
    wait_resp("t5_latency1", 3);
    wait_idle("t5_idle");

    // reset during WAIT abandons the operation
    never = 1'b1;
    set_req(1, 4'd3, 4'd3);
    tick();
    chk("t6_req_ready", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    tick(); tick();
    chk("t6_busy_wait", busy, 1);
    rst = 1'b0;
    tick();
    check_zero("t6_reset");
    tick();
    rst = 1'b1; never = 1'b0; lat = 3;
    set_req(0, 4'd2, 4'd2); push(0, 8'd4, 1'b0);
    set_req(3, 4'd1, 4'd1);
    tick();
    chk("t6_prio_req_ready", req_ready, 4'b0001);
    req_valid[0] = 1'b0;
    push(3, 8'd1, 1'b0);
    wait_resp("t6_latency", 4);
    wait_ready("t6_second_grant", 4'b1000);
    req_valid[3] = 1'b0;
    wait_drain("t6_drain");
    wait_idle("t6_idle");

    chk("final_scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
